// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM states, register-file zero, and opcode
// constants that the control unit and hazard logic agree on.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Decode helpers so the control unit derives id_uses_rt / ex_mem_read the same way.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return op == OP_LW;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard bundle between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_controller_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_freeze;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mem_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_flush, pipe_freeze, mem_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Five-stage pipeline hazard sequencer: load-use bubbles, taken-branch flushes,
// and data-memory wait freezes with a timeout into a sticky error state.
module hazard_stall_controller
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_controller_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t   state;
  logic [WAIT_W-1:0] wait_cnt;
  logic        mem_err_q;
  logic        lu, mw, err;
  logic        stall_inc, flush_inc;

  always_comb begin
    lu  = hz.ex_mem_read && (hz.ex_rt != REG_ZERO) &&
          ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    mw  = hz.mem_req && !hz.mem_ready;
    err = (state == ERROR);
    // A taken branch squashes the ID instruction, so a coincident load-use is not a stall.
    stall_inc = !err && (mw || (lu && !hz.ex_branch_taken));
    flush_inc = !err && !mw && hz.ex_branch_taken;
  end

  always_comb begin
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.pipe_freeze = 1'b0;
    if (!rst_n) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (err || mw) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.pipe_freeze = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (lu) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  // wait_cnt counts not-ready cycles including the one spent in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: if (mw) begin
          state    <= MEM_WAIT;
          wait_cnt <= WAIT_W'(1);
        end
        MEM_WAIT: begin
          if (!mw) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_LAST) begin
            state     <= ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERROR:   ;
        default: state <= RUN;
      endcase
    end
  end

  assign hz.mem_error = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: dut_a (16-bit counters) carries the main checks, dut_b mirrors
// the same stimulus with 2-bit counters to exercise saturation.
module tb_hazard_stall_controller;
  localparam logic [31:0] C_RUN    = 32'b11000; // {pc_en,ifid_en,ifid_flush,idex_flush,pipe_freeze}
  localparam logic [31:0] C_LU     = 32'b00010;
  localparam logic [31:0] C_BR     = 32'b11110;
  localparam logic [31:0] C_FREEZE = 32'b00001;
  localparam logic [31:0] C_RST    = 32'b00110;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  hazard_stall_controller_if #(.CNT_W(16)) ia ();
  hazard_stall_controller_if #(.CNT_W(2))  ib ();

  assign ib.id_rs           = ia.id_rs;
  assign ib.id_rt           = ia.id_rt;
  assign ib.id_uses_rt      = ia.id_uses_rt;
  assign ib.ex_mem_read     = ia.ex_mem_read;
  assign ib.ex_rt           = ia.ex_rt;
  assign ib.ex_branch_taken = ia.ex_branch_taken;
  assign ib.mem_req         = ia.mem_req;
  assign ib.mem_ready       = ia.mem_ready;

  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ia));
  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .hz(ib));

  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {ia.pc_en, ia.ifid_en, ia.ifid_flush, ia.idex_flush, ia.pipe_freeze};
  assign ctl_b = {ib.pc_en, ib.ifid_en, ib.ifid_flush, ib.idex_flush, ib.pipe_freeze};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.id_rs = 5'd0; ia.id_rt = 5'd0; ia.id_uses_rt = 1'b0;
    ia.ex_mem_read = 1'b0; ia.ex_rt = 5'd0; ia.ex_branch_taken = 1'b0;
    ia.mem_req = 1'b0; ia.mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    chk("reset_ctl", 32'(ctl_a), C_RST);
    chk("reset_err", 32'(ia.mem_error), 0);
    chk("reset_stall", 32'(ia.stall_cnt), 0);
    chk("reset_flush", 32'(ia.flush_cnt), 0);
    chk("reset_ctl_b", 32'(ctl_b), C_RST);
    repeat (2) tick();
    rst_n = 1'b1; #1;
    chk("idle_ctl", 32'(ctl_a), C_RUN);

    // load-use on rs: one bubble
    ia.ex_mem_read = 1'b1; ia.ex_rt = 5'd8; ia.id_rs = 5'd8; #1;
    chk("lu_rs_ctl", 32'(ctl_a), C_LU);
    tick();
    ia.ex_mem_read = 1'b0; #1;
    chk("lu_rs_after", 32'(ctl_a), C_RUN);
    chk("lu_rs_stall", 32'(ia.stall_cnt), 1);

    // load into $0 never stalls
    ia.ex_mem_read = 1'b1; ia.ex_rt = 5'd0; ia.id_rs = 5'd0; #1;
    chk("lu_r0_ctl", 32'(ctl_a), C_RUN);
    tick();
    chk("lu_r0_stall", 32'(ia.stall_cnt), 1);

    // rt-only dependence
    ia.ex_rt = 5'd8; ia.id_rs = 5'd3; ia.id_rt = 5'd8; ia.id_uses_rt = 1'b0; #1;
    chk("rt_unused_ctl", 32'(ctl_a), C_RUN);
    tick();
    ia.id_uses_rt = 1'b1; #1;
    chk("rt_used_ctl", 32'(ctl_a), C_LU);
    tick();
    idle(); #1;
    chk("rt_used_stall", 32'(ia.stall_cnt), 2);

    // branch beats load-use
    ia.ex_mem_read = 1'b1; ia.ex_rt = 5'd8; ia.id_rs = 5'd8; ia.ex_branch_taken = 1'b1; #1;
    chk("br_lu_ctl", 32'(ctl_a), C_BR);
    tick();
    idle(); #1;
    chk("br_lu_flush", 32'(ia.flush_cnt), 1);
    chk("br_lu_stall", 32'(ia.stall_cnt), 2);

    // 3-cycle memory wait
    ia.mem_req = 1'b1; ia.mem_ready = 1'b0; #1;
    chk("mw_c1", 32'(ctl_a), C_FREEZE);
    tick();
    chk("mw_c2", 32'(ctl_a), C_FREEZE);
    tick();
    chk("mw_c3", 32'(ctl_a), C_FREEZE);
    tick();
    ia.mem_ready = 1'b1; #1;
    chk("mw_release", 32'(ctl_a), C_RUN);
    chk("mw_stall", 32'(ia.stall_cnt), 5);
    tick();
    idle(); #1;
    chk("mw_stall_hold", 32'(ia.stall_cnt), 5);
    chk("sat_b_mw", 32'(ib.stall_cnt), 3);

    // single-cycle wait costs one freeze
    ia.mem_req = 1'b1; #1;
    chk("mw1_freeze", 32'(ctl_a), C_FREEZE);
    tick();
    ia.mem_ready = 1'b1; #1;
    chk("mw1_run", 32'(ctl_a), C_RUN);
    tick();
    idle(); #1;
    chk("mw1_stall", 32'(ia.stall_cnt), 6);

    // branch held through a wait flushes once after release
    ia.mem_req = 1'b1; ia.ex_branch_taken = 1'b1; #1;
    chk("brw_c1", 32'(ctl_a), C_FREEZE);
    tick();
    chk("brw_c2", 32'(ctl_a), C_FREEZE);
    tick();
    ia.mem_ready = 1'b1; #1;
    chk("brw_flush_ctl", 32'(ctl_a), C_BR);
    tick();
    idle(); #1;
    chk("brw_flush_cnt", 32'(ia.flush_cnt), 2);
    chk("brw_stall", 32'(ia.stall_cnt), 8);
    chk("brw_flush_b", 32'(ib.flush_cnt), 2);

    // another load-use: dut_b stays saturated
    ia.ex_mem_read = 1'b1; ia.ex_rt = 5'd9; ia.id_rs = 5'd9; tick();
    idle(); #1;
    chk("lu9_stall", 32'(ia.stall_cnt), 9);
    chk("sat_b_lu", 32'(ib.stall_cnt), 3);

    // timeout: 4 not-ready cycles reach ERROR
    ia.mem_req = 1'b1; ia.mem_ready = 1'b0;
    repeat (3) tick();
    chk("to_err_early", 32'(ia.mem_error), 0);
    tick();
    chk("to_err_set", 32'(ia.mem_error), 1);
    chk("to_ctl", 32'(ctl_a), C_FREEZE);
    chk("to_stall", 32'(ia.stall_cnt), 13);
    ia.mem_ready = 1'b1; ia.ex_branch_taken = 1'b1; #1;
    chk("err_ctl", 32'(ctl_a), C_FREEZE);
    tick();
    chk("err_sticky", 32'(ia.mem_error), 1);
    chk("err_no_stall", 32'(ia.stall_cnt), 13);
    chk("err_no_flush", 32'(ia.flush_cnt), 2);
    idle();

    // reset clears ERROR asynchronously
    rst_n = 1'b0; #1;
    chk("rst_err_clr", 32'(ia.mem_error), 0);
    chk("rst_stall_clr", 32'(ia.stall_cnt), 0);
    chk("rst_ctl", 32'(ctl_a), C_RST);
    tick();
    rst_n = 1'b1; #1;
    chk("rst_rel_ctl", 32'(ctl_a), C_RUN);

    // reset in the middle of a wait aborts it
    ia.mem_req = 1'b1;
    tick(); tick();
    chk("mwr_stall", 32'(ia.stall_cnt), 2);
    rst_n = 1'b0; #1;
    chk("mwr_stall_clr", 32'(ia.stall_cnt), 0);
    chk("mwr_flush_clr", 32'(ia.flush_cnt), 0);
    chk("mwr_ctl", 32'(ctl_a), C_RST);
    tick();
    ia.mem_req = 1'b0; rst_n = 1'b1; #1;
    chk("mwr_rel_ctl", 32'(ctl_a), C_RUN);
    // a fresh wait must start its timeout from zero
    ia.mem_req = 1'b1;
    repeat (3) tick();
    chk("mwr_fresh_to", 32'(ia.mem_error), 0);
    ia.mem_ready = 1'b1; #1;
    chk("mwr_fresh_run", 32'(ctl_a), C_RUN);
    tick();
    chk("mwr_fresh_stall", 32'(ia.stall_cnt), 3);
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the five-stage pipeline around hazards by driving PC/IF-ID write enables, flushes, and the `stall` input of the control unit (bubble insertion).
- Handles three hazards:
  - load-use data hazards (one-cycle bubble);
  - taken branches resolved in EX (flush IF/ID and ID/EX);
  - data-memory wait states (full pipeline freeze with timeout).
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64: max consecutive not-ready cycles in MEM_WAIT before ERROR.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous and active-low.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, bne, sw).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination rt of the EX load.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to nop.
- idex_flush  out  1  load bubble into ID/EX; also wired to the control unit `stall`.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_error  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. The state register and wait counter (width clog2(MEM_TIMEOUT+1)) reset asynchronously to RUN and 0.
- Hazard detection is combinational on current inputs. Outputs are combinational on state and hazard terms.
- Load-use hazard (lu):
  - lu = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
  - A load into $0 never stalls.
- Memory wait (mw): mw = mem_req && !mem_ready.
- Priority, highest first:
  - ERROR: all enables 0, pipe_freeze=1, flushes 0.
  - mw: pc_en=0, ifid_en=0, pipe_freeze=1, flushes 0.
  - ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - lu: pc_en=0, ifid_en=0, idex_flush=1.
  - Otherwise: pc_en=1, ifid_en=1, everything else 0.
- Branch and load-use in the same cycle: the branch wins. The ID instruction is squashed, so there is no stall and lu is not counted.
- Branch held during mw: EX is frozen, so ex_branch_taken stays high. The flush happens in the cycle mw drops and is counted once.
- Transitions:
  - RUN→MEM_WAIT when mw; the wait counter loads 1.
  - MEM_WAIT stays while mw, incrementing the counter.
  - MEM_WAIT→RUN the cycle mem_ready=1; the counter clears.
  - MEM_WAIT→ERROR when the counter reaches MEM_TIMEOUT with mw still true. mem_error is set on the same edge.
  - ERROR is left only by reset.
  - A single-cycle mw (ready arrives the next cycle) costs exactly one freeze cycle.
- Counters:
  - stall_cnt +1 per clock edge where (mw || lu-effective) && state!=ERROR.
  - flush_cnt +1 per edge where a branch flush is applied.
  - Both saturate at all-ones and never wrap.
- Reset:
  - While rst_n=0, outputs are pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pipe_freeze=0, mem_error=0, and both counters 0.
  - Reset asserted mid-MEM_WAIT aborts the wait; RUN follows on release.
  - The first clock after deassertion follows the normal rules.

Decomposition:
- Shared package cpu_pkg:
  - FSM state typedef (RUN/MEM_WAIT/ERROR).
  - REG_ZERO=5'd0.
  - Opcode/funct constants reused with the control unit.
- Sub-module sat_counter (parameter W; inputs inc, async active-low reset; output count) is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rt=8, id_rs=8.
  - Response: exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0→1.
  - With ex_rt=0, no stall.
- rt-only dependence:
  - With id_rt=8 and id_uses_rt=0, no stall.
  - With id_uses_rt=1, one-cycle stall.
- Branch vs load-use:
  - Stimulus: ex_branch_taken=1 together with an lu condition.
  - Response: ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- Memory wait:
  - Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then ready.
  - Response: pipe_freeze=1 for 3 cycles, then RUN; stall_cnt=3.
  - A branch held during the wait flushes once after release.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ready held 0.
  - Response: ERROR after 4 wait cycles; mem_error=1 stays set after ready rises; only rst_n=0 clears it.
- Saturation and reset:
  - Stimulus: CNT_W=2, 5 lu stalls.
  - Response: stall_cnt=3.
  - Asserting rst_n mid-MEM_WAIT zeroes the counters and returns the FSM to RUN asynchronously.
